// File: rtl/decode_group_stage.sv
// decode_group_stage: WIDTH-lane RV32IM decoder feeding a registered output
// stage with a one-entry skid buffer. Groups carry a wrapping sequence tag.
package decode_group_stage_pkg;
   typedef struct packed {
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  rs1_s;
      logic [4:0]  rs2_s;
      logic [4:0]  rd_s;
      logic [31:0] immediate;
      logic [31:0] inst;
      logic [31:0] pc_curr;
      logic [31:0] pc_next;
      logic        rs1_needed;
      logic        rs2_needed;
      logic        op1_is_pc;
      logic        op2_is_imm;
      logic        rd_write;
      logic        alu_en;
      logic        cmp_en;
      logic        mul_en;
      logic        div_en;
      logic [3:0]  alu_operation;   // {sub/sra select, funct3}
      logic [2:0]  cmp_operation;   // branch funct3 encoding (slt -> blt, sltu -> bltu)
      logic [1:0]  mul_type;
      logic [1:0]  div_type;
      logic        is_branch;
      logic        is_jump;
      logic        is_load;
      logic        is_store;
      logic        illegal;
   } decode_info_t;
endpackage

module decode_group_stage
   import decode_group_stage_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int SEQ_W = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        in_lane_valid,
   input  logic [WIDTH-1:0][31:0]  in_inst,
   input  logic [WIDTH-1:0][31:0]  in_pc_curr,
   input  logic [WIDTH-1:0][31:0]  in_pc_next,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_lane_valid,
   output logic [SEQ_W-1:0]        out_seq,
   output decode_info_t [WIDTH-1:0] out_info
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

   state_t                    state, state_next;
   logic                      load_m_in, load_m_skid, load_s;
   logic [SEQ_W-1:0]          seq_cnt;
   decode_info_t [WIDTH-1:0]  dec_info_p0;
   logic [WIDTH-1:0]          m_lane_valid, s_lane_valid;
   logic [SEQ_W-1:0]          m_seq, s_seq;
   decode_info_t [WIDTH-1:0]  m_info, s_info;

   function automatic logic [31:0] imm_i(input logic [31:0] w);
      return {{20{w[31]}}, w[31:20]};
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] w);
      return {{20{w[31]}}, w[31:25], w[11:7]};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] w);
      return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_u(input logic [31:0] w);
      return {w[31:12], 12'b0};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] w);
      return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
   endfunction

   function automatic decode_info_t decode_lane(input logic [31:0] w,
                                                input logic [31:0] pc_curr,
                                                input logic [31:0] pc_next);
      decode_info_t d;
      decode_info_t base;
      logic [2:0]   f3;
      logic [6:0]   f7;
      f3 = w[14:12];
      f7 = w[31:25];
      base           = '0;
      base.opcode    = w[6:0];
      base.funct3    = f3;
      base.funct7    = f7;
      base.rs1_s     = w[19:15];
      base.rs2_s     = w[24:20];
      base.rd_s      = w[11:7];
      base.inst      = w;
      base.pc_curr   = pc_curr;
      base.pc_next   = pc_next;
      d = base;
      case (w[6:0])
         OPC_LUI: begin
            d.immediate = imm_u(w); d.alu_en = 1'b1; d.op2_is_imm = 1'b1; d.rd_write = 1'b1;
         end
         OPC_AUIPC: begin
            d.immediate = imm_u(w); d.alu_en = 1'b1; d.op1_is_pc = 1'b1;
            d.op2_is_imm = 1'b1; d.rd_write = 1'b1;
         end
         OPC_JAL: begin
            d.immediate = imm_j(w); d.alu_en = 1'b1; d.op1_is_pc = 1'b1;
            d.op2_is_imm = 1'b1; d.is_jump = 1'b1; d.rd_write = 1'b1;
         end
         OPC_JALR: begin
            d.immediate = imm_i(w); d.alu_en = 1'b1; d.rs1_needed = 1'b1;
            d.op2_is_imm = 1'b1; d.is_jump = 1'b1; d.rd_write = 1'b1;
         end
         OPC_BRANCH: begin
            d.immediate = imm_b(w); d.cmp_en = 1'b1; d.cmp_operation = f3;
            d.rs1_needed = 1'b1; d.rs2_needed = 1'b1; d.is_branch = 1'b1;
            d.illegal = (f3[2:1] == 2'b01);
         end
         OPC_LOAD: begin
            d.immediate = imm_i(w); d.alu_en = 1'b1; d.rs1_needed = 1'b1;
            d.op2_is_imm = 1'b1; d.is_load = 1'b1; d.rd_write = 1'b1;
            d.illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
         end
         OPC_STORE: begin
            d.immediate = imm_s(w); d.alu_en = 1'b1; d.rs1_needed = 1'b1;
            d.rs2_needed = 1'b1; d.op2_is_imm = 1'b1; d.is_store = 1'b1;
            d.illegal = (f3 > 3'b010);
         end
         OPC_OP_IMM: begin
            d.immediate = imm_i(w); d.rs1_needed = 1'b1; d.op2_is_imm = 1'b1; d.rd_write = 1'b1;
            if (f3 == 3'b010 || f3 == 3'b011) begin
               d.cmp_en = 1'b1;
               d.cmp_operation = (f3 == 3'b010) ? 3'b100 : 3'b110;
            end else begin
               d.alu_en = 1'b1;
               // Only the right-shift form uses funct7[5] as the arithmetic select.
               d.alu_operation = {(f3 == 3'b101) && f7[5], f3};
               if (f3 == 3'b001) d.illegal = (f7 != 7'b0000000);
               if (f3 == 3'b101) d.illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            end
         end
         OPC_OP: begin
            d.rs1_needed = 1'b1; d.rs2_needed = 1'b1; d.rd_write = 1'b1;
            if (f7 == 7'b0000001) begin
               if (f3[2]) begin
                  d.div_en = 1'b1; d.div_type = f3[1:0];
               end else begin
                  d.mul_en = 1'b1; d.mul_type = f3[1:0];
               end
            end else if (f7 == 7'b0000000) begin
               if (f3 == 3'b010 || f3 == 3'b011) begin
                  d.cmp_en = 1'b1;
                  d.cmp_operation = (f3 == 3'b010) ? 3'b100 : 3'b110;
               end else begin
                  d.alu_en = 1'b1; d.alu_operation = {1'b0, f3};
               end
            end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
               d.alu_en = 1'b1; d.alu_operation = {1'b1, f3};
            end else begin
               d.illegal = 1'b1;
            end
         end
         default: d.illegal = 1'b1;
      endcase
      // Illegal lanes keep only the raw instruction fields.
      if (d.illegal) begin
         d = base;
         d.illegal = 1'b1;
      end
      if (d.rd_s == 5'd0) d.rd_write = 1'b0;
      return d;
   endfunction

   // Decode every lane of the incoming group.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         dec_info_p0[i] = decode_lane(in_inst[i], in_pc_curr[i], in_pc_next[i]);
      end
   end

   // Buffer control: next state, handshake outputs and register load strobes.
   always_comb begin
      state_next  = state;
      load_m_in   = 1'b0;
      load_m_skid = 1'b0;
      load_s      = 1'b0;
      in_ready    = (state != ST_SKID);
      out_valid   = (state != ST_EMPTY);
      if (flush) begin
         state_next = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (in_valid) begin
                  load_m_in  = 1'b1;
                  state_next = ST_FULL;
               end
            end
            ST_FULL: begin
               if (in_valid && out_ready) begin
                  load_m_in = 1'b1;
               end else if (in_valid) begin
                  load_s     = 1'b1;
                  state_next = ST_SKID;
               end else if (out_ready) begin
                  state_next = ST_EMPTY;
               end
            end
            ST_SKID: begin
               if (out_ready) begin
                  load_m_skid = 1'b1;
                  state_next  = ST_FULL;
               end
            end
            default: state_next = ST_EMPTY;
         endcase
      end
   end

   // State register and sequence counter; the counter only moves on kept accepts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_EMPTY;
         seq_cnt <= '0;
      end else begin
         state <= state_next;
         if (load_m_in || load_s) seq_cnt <= seq_cnt + 1'b1;
      end
   end

   // ---- stage 1: main output register ----
   // Main register drives the outputs directly, so it clears on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_lane_valid <= '0;
         m_seq        <= '0;
         m_info       <= '0;
      end else if (load_m_in) begin
         m_lane_valid <= in_lane_valid;
         m_seq        <= seq_cnt;
         m_info       <= dec_info_p0;
      end else if (load_m_skid) begin
         m_lane_valid <= s_lane_valid;
         m_seq        <= s_seq;
         m_info       <= s_info;
      end
   end

   // Skid register catches the group accepted while the consumer stalls.
   always_ff @(posedge clk) begin
      if (load_s) begin
         s_lane_valid <= in_lane_valid;
         s_seq        <= seq_cnt;
         s_info       <= dec_info_p0;
      end
   end

   assign out_lane_valid = m_lane_valid;
   assign out_seq        = m_seq;
   assign out_info       = m_info;

endmodule

// File: tb/tb_decode_group_stage.sv
// tb_decode_group_stage: randomized and directed stimulus with a queue
// scoreboard; a mnemonic-level decode model and a 2-deep FIFO occupancy model.
module tb_decode_group_stage;
   import decode_group_stage_pkg::*;

   localparam int WIDTH = 2;
   localparam int SEQ_W = 6;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    flush;
   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH-1:0]        in_lane_valid;
   logic [WIDTH-1:0][31:0]  in_inst;
   logic [WIDTH-1:0][31:0]  in_pc_curr;
   logic [WIDTH-1:0][31:0]  in_pc_next;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        out_lane_valid;
   logic [SEQ_W-1:0]        out_seq;
   decode_info_t [WIDTH-1:0] out_info;

   decode_group_stage #(.WIDTH(WIDTH), .SEQ_W(SEQ_W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_lane_valid(in_lane_valid), .in_inst(in_inst), .in_pc_curr(in_pc_curr),
      .in_pc_next(in_pc_next), .out_valid(out_valid), .out_ready(out_ready),
      .out_lane_valid(out_lane_valid), .out_seq(out_seq), .out_info(out_info)
   );

   always #5 clk = ~clk;

   typedef enum {K_LUI, K_AUIPC, K_JAL, K_JALR, K_BRANCH, K_LOAD, K_STORE,
                 K_ALUI, K_CMPI, K_ALUR, K_CMPR, K_MUL, K_DIV, K_ILL} kind_e;

   typedef struct {
      logic [WIDTH-1:0] lv;
      logic [SEQ_W-1:0] seq;
      decode_info_t     info [WIDTH];
   } exp_t;

   exp_t             sb[$];
   logic [SEQ_W-1:0] mseq;
   int               n_vec = 0;
   int               n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_info(input string name, input decode_info_t act, input decode_info_t exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Which instruction class the word belongs to, from the ISA tables.
   function automatic kind_e classify(input logic [31:0] w);
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = w[14:12];
      f7 = w[31:25];
      case (w[6:0])
         7'h37: return K_LUI;
         7'h17: return K_AUIPC;
         7'h6F: return K_JAL;
         7'h67: return K_JALR;
         7'h63: return (f3 == 2 || f3 == 3) ? K_ILL : K_BRANCH;
         7'h03: return (f3 == 3 || f3 == 6 || f3 == 7) ? K_ILL : K_LOAD;
         7'h23: return (f3 > 2) ? K_ILL : K_STORE;
         7'h13: begin
            if (f3 == 1) return (f7 == 0) ? K_ALUI : K_ILL;
            if (f3 == 5) return (f7 == 0 || f7 == 7'h20) ? K_ALUI : K_ILL;
            if (f3 == 2 || f3 == 3) return K_CMPI;
            return K_ALUI;
         end
         7'h33: begin
            if (f7 == 7'h01) return (f3 >= 4) ? K_DIV : K_MUL;
            if (f7 == 7'h00) return (f3 == 2 || f3 == 3) ? K_CMPR : K_ALUR;
            if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) return K_ALUR;
            return K_ILL;
         end
         default: return K_ILL;
      endcase
   endfunction

   function automatic decode_info_t model(input logic [31:0] w, input logic [31:0] pc,
                                          input logic [31:0] npc);
      decode_info_t e;
      kind_e        k;
      int           imm;
      logic [2:0]   f3;
      f3 = w[14:12];
      k  = classify(w);
      e = '0;
      e.opcode = w[6:0]; e.funct3 = f3; e.funct7 = w[31:25];
      e.rs1_s = w[19:15]; e.rs2_s = w[24:20]; e.rd_s = w[11:7];
      e.inst = w; e.pc_curr = pc; e.pc_next = npc;
      if (k == K_ILL) begin
         e.illegal = 1'b1;
         return e;
      end
      case (k)
         K_LUI, K_AUIPC:                  imm = {w[31:12], 12'h000};
         K_JAL:                           imm = $signed({w[31], w[19:12], w[20], w[30:21]}) * 2;
         K_JALR, K_LOAD, K_ALUI, K_CMPI:  imm = $signed(w[31:20]);
         K_STORE:                         imm = $signed({w[31:25], w[11:7]});
         K_BRANCH:                        imm = $signed({w[31], w[7], w[30:25], w[11:8]}) * 2;
         default:                         imm = 0;
      endcase
      e.immediate  = imm;
      e.rs1_needed = !(k inside {K_LUI, K_AUIPC, K_JAL});
      e.rs2_needed = k inside {K_BRANCH, K_STORE, K_ALUR, K_CMPR, K_MUL, K_DIV};
      e.op1_is_pc  = k inside {K_AUIPC, K_JAL};
      e.op2_is_imm = k inside {K_LUI, K_AUIPC, K_JAL, K_JALR, K_LOAD, K_STORE, K_ALUI, K_CMPI};
      e.rd_write   = !(k inside {K_BRANCH, K_STORE}) && (w[11:7] != 0);
      e.alu_en     = k inside {K_LUI, K_AUIPC, K_JAL, K_JALR, K_LOAD, K_STORE, K_ALUI, K_ALUR};
      e.cmp_en     = k inside {K_BRANCH, K_CMPI, K_CMPR};
      e.mul_en     = (k == K_MUL);
      e.div_en     = (k == K_DIV);
      if (k == K_ALUR) e.alu_operation = f3 + ((w[31:25] == 7'h20) ? 8 : 0);
      if (k == K_ALUI) e.alu_operation = f3 + ((f3 == 5 && w[31:25] == 7'h20) ? 8 : 0);
      if (k == K_BRANCH) e.cmp_operation = f3;
      if (k inside {K_CMPI, K_CMPR}) e.cmp_operation = (f3 == 2) ? 3'd4 : 3'd6;
      if (k == K_MUL) e.mul_type = f3[1:0];
      if (k == K_DIV) e.div_type = f3[1:0];
      e.is_branch = (k == K_BRANCH);
      e.is_jump   = k inside {K_JAL, K_JALR};
      e.is_load   = (k == K_LOAD);
      e.is_store  = (k == K_STORE);
      return e;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [6:0] opc;
      logic [6:0] f7;
      case ($urandom_range(0, 10))
         0: opc = 7'h37;  1: opc = 7'h17;  2: opc = 7'h6F;  3: opc = 7'h67;
         4: opc = 7'h63;  5: opc = 7'h03;  6: opc = 7'h23;  7: opc = 7'h13;
         8, 9: opc = 7'h33;
         default: opc = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
         0: f7 = 7'h00;  1: f7 = 7'h20;  2: f7 = 7'h01;
         default: f7 = 7'($urandom);
      endcase
      return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
   endfunction

   task automatic set_lanes(input logic [WIDTH-1:0] m, input logic [31:0] i0, input logic [31:0] i1);
      in_lane_valid = m;
      in_inst[0] = i0;
      in_inst[1] = i1;
      for (int i = 0; i < WIDTH; i++) begin
         in_pc_curr[i] = $urandom & 32'hFFFF_FFFC;
         in_pc_next[i] = in_pc_curr[i] + 4;
      end
   endtask

   // Offer one group for a single cycle; caller guarantees in_ready is high.
   task automatic send(input logic [WIDTH-1:0] m, input logic [31:0] i0, input logic [31:0] i1);
      set_lanes(m, i0, i1);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Monitor: occupancy model, output compare on transfer, expectation push on accept.
   always @(negedge clk) begin
      exp_t e;
      bit   mready;
      if (rst) begin
         sb.delete();
         mseq = '0;
      end else begin
         mready = (sb.size() < 2);
         chk("out_valid", out_valid, sb.size() > 0);
         chk("in_ready", in_ready, mready);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_output: got seq %0d expected none", out_seq);
            end else begin
               e = sb.pop_front();
               chk("out_lane_valid", out_lane_valid, e.lv);
               chk("out_seq", out_seq, e.seq);
               for (int l = 0; l < WIDTH; l++) begin
                  if (e.lv[l]) chk_info($sformatf("out_info[%0d]", l), out_info[l], e.info[l]);
               end
            end
         end
         if (flush) begin
            sb.delete();
         end else if (in_valid && mready) begin
            e.lv  = in_lane_valid;
            e.seq = mseq;
            for (int l = 0; l < WIDTH; l++) e.info[l] = model(in_inst[l], in_pc_curr[l], in_pc_next[l]);
            sb.push_back(e);
            mseq = mseq + 1'b1;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      set_lanes(2'b01, 32'h0000_0013, 32'h0000_0013);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_seq", out_seq, 0);
      chk("rst_out_lane_valid", out_lane_valid, 0);
      chk_info("rst_out_info0", out_info[0], '0);
      chk_info("rst_out_info1", out_info[1], '0);
      rst = 1'b0;

      // addi x1,x0,5
      out_ready = 1'b1;
      send(2'b01, 32'h0050_0093, 32'h0);
      @(negedge clk);
      chk("addi_valid", out_valid, 1);
      chk("addi_imm", out_info[0].immediate, 5);
      chk("addi_rs1_needed", out_info[0].rs1_needed, 1);
      chk("addi_rs2_needed", out_info[0].rs2_needed, 0);
      chk("addi_alu_en", out_info[0].alu_en, 1);
      chk("addi_rd_write", out_info[0].rd_write, 1);
      chk("addi_seq", out_seq, 0);

      // mul x3,x1,x2 ; divu x3,x1,x2
      send(2'b11, 32'h0220_81B3, 32'h0220_D1B3);
      @(negedge clk);
      chk("mul_en", out_info[0].mul_en, 1);
      chk("mul_type", out_info[0].mul_type, 0);
      chk("div_en", out_info[1].div_en, 1);
      chk("div_type", out_info[1].div_type, 1);
      chk("muldiv_alu_en", {out_info[0].alu_en, out_info[1].alu_en}, 0);
      chk("muldiv_seq", out_seq, 1);

      // jalr x1,0(x2) ; all-ones word
      send(2'b11, 32'h0001_00E7, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("jalr_is_jump", out_info[0].is_jump, 1);
      chk("jalr_rs1_needed", out_info[0].rs1_needed, 1);
      chk("jalr_imm", out_info[0].immediate, 0);
      chk("ill_illegal", out_info[1].illegal, 1);
      chk("ill_rd_write", out_info[1].rd_write, 0);

      // Reset while a group is held: it vanishes without a transfer.
      out_ready = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_seq", out_seq, 0);
      chk_info("midrst_out_info0", out_info[0], '0);
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;

      // Backpressure: two accepted, third stalls, then drain in order.
      in_valid = 1'b1;
      set_lanes(2'b01, 32'h0010_0113, 32'h0);
      @(posedge clk); #1;
      set_lanes(2'b11, 32'h0020_0193, 32'h4020_8233);
      @(posedge clk); #1;
      set_lanes(2'b01, 32'h0030_0213, 32'h0);
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_seq0", out_seq, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_seq1", out_seq, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_seq2", out_seq, 2);

      // Flush while in SKID with a group offered.
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      out_ready = 1'b0;
      in_valid = 1'b1;
      set_lanes(2'b01, 32'h0000_0517, 32'h0);
      @(posedge clk); #1;
      set_lanes(2'b01, 32'h0080_006F, 32'h0);
      @(posedge clk); #1;
      set_lanes(2'b01, 32'h1234_50B7, 32'h0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", out_valid, 0);
      chk("flush_in_ready", in_ready, 1);
      send(2'b01, 32'h0041_2083, 32'h0);
      @(negedge clk);
      chk("flush_next_seq", out_seq, 2);

      // Flush in FULL drops the simultaneous accept without consuming a tag.
      in_valid = 1'b1;
      set_lanes(2'b01, 32'h0011_2223, 32'h0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_full_out_valid", out_valid, 0);
      send(2'b01, 32'hFE20_8EE3, 32'h0);
      @(negedge clk);
      chk("flush_full_next_seq", out_seq, 3);

      // Full-rate stream across the tag wrap.
      out_ready = 1'b1;
      for (int g = 0; g < 70; g++) begin
         set_lanes($urandom_range(0, 1) ? 2'b11 : 2'b01, rand_inst(), rand_inst());
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;

      // Random traffic with backpressure and occasional flush.
      for (int c = 0; c < 400; c++) begin
         set_lanes($urandom_range(0, 1) ? 2'b11 : 2'b01, rand_inst(), rand_inst());
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b1;

      begin
         int budget;
         budget = 0;
         while (sb.size() != 0 && budget < 20) begin
            @(posedge clk); #1;
            budget++;
         end
      end
      @(negedge clk);
      chk("drain_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
